// File: rtl/tribus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tribus_pkg
// Brief    : Shared types and default constants for the tristate bus reader.
// Revision : 1.0  initial release
// ============================================================================
package tribus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } tribus_state_e;

    localparam int TRIBUS_W          = 4;
    localparam int TRIBUS_NSRC       = 4;
    localparam int TRIBUS_SETTLE_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/tribus_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : tribus_reader_if
// Brief    : Request and result handshakes between the reader and its client.
// Revision : 1.0  initial release
// ============================================================================
interface tribus_reader_if #(
    parameter int W = 4
);
    logic         req_valid;
    logic [3:0]   req_src;
    logic         req_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output req_valid, req_src, out_ready,
        input  req_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  req_valid, req_src, out_ready,
        output req_ready, out_data, out_err, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/bt.sv
`default_nettype none
// ============================================================================
// Module   : BT
// Brief    : Tristate buffer; drives S onto Y while EN is high, else floats.
// Revision : 1.0  initial release
// ============================================================================
module BT #(
    parameter int W = 4
) (
    input  wire [W-1:0] S,
    input  wire         EN,
    output wire [W-1:0] Y
);
    assign Y = EN ? S : {W{1'bz}};
endmodule
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dec
// Brief    : Index to one-hot decoder with enable and out-of-range flag.
// Revision : 1.0  initial release
// ============================================================================
module onehot_dec #(
    parameter int N_SRC = 4,
    parameter int IW    = 4
) (
    input  logic             en,
    input  logic [IW-1:0]    idx,
    output logic [N_SRC-1:0] onehot,
    output logic             oor
);
    // Extra bit so N_SRC = 2**IW still compares correctly.
    assign oor = ({1'b0, idx} >= (IW+1)'(N_SRC));

    for (genvar i = 0; i < N_SRC; i++) begin : g_bit
        assign onehot[i] = en & ~oor & (idx == IW'(i));
    end
endmodule
`default_nettype wire

// File: rtl/tribus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tribus_reader
// Brief    : Enables one tristate source, waits a settle time, captures the bus.
// Revision : 1.0  initial release
// ============================================================================
module tribus_reader
    import tribus_pkg::*;
#(
    parameter int N_SRC  = TRIBUS_NSRC,
    parameter int W      = TRIBUS_W,
    parameter int SETTLE = TRIBUS_SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    tribus_reader_if.slave   ifc,
    output logic [N_SRC-1:0] bus_en,
    input  logic [W-1:0]     bus_in
);
    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_DRIVE = DRIVE;
    localparam logic [1:0] c_HOLD  = HOLD;

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [N_SRC-1:0] r_sel;
    logic [W-1:0]     r_data;
    logic             r_err;

    logic [N_SRC-1:0] w_onehot;
    logic             w_oor;
    logic             w_idle;

    assign w_idle = (r_state == c_IDLE);

    onehot_dec #(
        .N_SRC (N_SRC),
        .IW    (4)
    ) u_dec (
        .en     (w_idle),
        .idx    (ifc.req_src),
        .onehot (w_onehot),
        .oor    (w_oor)
    );

    // Enables come only from the latched selection, so req_src is ignored after accept.
    assign bus_en        = (r_state == c_DRIVE) ? r_sel : '0;
    assign ifc.req_ready = w_idle;
    assign ifc.out_valid = (r_state == c_HOLD);
    assign ifc.out_data  = r_data;
    assign ifc.out_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_sel   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ifc.req_valid) begin
                        if (w_oor) begin
                            r_data  <= '0;
                            r_err   <= 1'b1;
                            r_state <= c_HOLD;
                        end else begin
                            r_sel   <= w_onehot;
                            r_cnt   <= 4'(SETTLE);
                            r_state <= c_DRIVE;
                        end
                    end
                end
                c_DRIVE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_data  <= bus_in;
                        r_err   <= 1'b0;
                        r_state <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (ifc.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tribus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tribus_reader
// Brief    : Directed bench: four BT sources on one bus read through the reader.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tribus_reader;
    logic       clk;
    logic       rst_n;
    wire  [3:0] bus;
    logic [3:0] bus_en;

    int vectors;
    int miscompares;
    int multi_en_seen;
    int any_en_seen;

    tribus_reader_if #(.W(4)) ifc ();

    tribus_reader #(.N_SRC(4), .W(4), .SETTLE(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ifc    (ifc.slave),
        .bus_en (bus_en),
        .bus_in (bus)
    );

    BT #(.W(4)) u_bt0 (.S(4'h3), .EN(bus_en[0]), .Y(bus));
    BT #(.W(4)) u_bt1 (.S(4'hA), .EN(bus_en[1]), .Y(bus));
    BT #(.W(4)) u_bt2 (.S(4'h5), .EN(bus_en[2]), .Y(bus));
    BT #(.W(4)) u_bt3 (.S(4'hF), .EN(bus_en[3]), .Y(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(bus_en) > 1) multi_en_seen++;
        if (bus_en != 4'b0000)      any_en_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_src   = 4'd0;
        ifc.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        vectors++; if (bus_en !== 4'b0000) begin miscompares++; $display("FAIL reset_bus_en got=%b exp=0000", bus_en); end
        vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
        vectors++; if (ifc.out_data !== 4'h0) begin miscompares++; $display("FAIL reset_out_data got=%h exp=0", ifc.out_data); end
        vectors++; if (ifc.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_out_err got=%b exp=0", ifc.out_err); end
        vectors++; if (ifc.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", ifc.req_ready); end
    endtask

    task automatic test_legal_read();
        ifc.out_ready = 1'b0;
        ifc.req_src   = 4'd2;
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        ifc.req_src   = 4'd3;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (bus_en !== 4'b0100) begin miscompares++; $display("FAIL legal_bus_en cyc=%0d got=%b exp=0100", i, bus_en); end
            vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL legal_early_valid cyc=%0d got=%b exp=0", i, ifc.out_valid); end
            tick();
        end
        vectors++; if (ifc.out_valid !== 1'b1) begin miscompares++; $display("FAIL legal_valid got=%b exp=1", ifc.out_valid); end
        vectors++; if (ifc.out_data !== 4'h5) begin miscompares++; $display("FAIL legal_data got=%h exp=5", ifc.out_data); end
        vectors++; if (ifc.out_err !== 1'b0) begin miscompares++; $display("FAIL legal_err got=%b exp=0", ifc.out_err); end
        vectors++; if (bus_en !== 4'b0000) begin miscompares++; $display("FAIL legal_hold_bus_en got=%b exp=0000", bus_en); end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL legal_release_valid got=%b exp=0", ifc.out_valid); end
        vectors++; if (ifc.req_ready !== 1'b1) begin miscompares++; $display("FAIL legal_release_ready got=%b exp=1", ifc.req_ready); end
    endtask

    task automatic test_backpressure();
        ifc.out_ready = 1'b0;
        ifc.req_src   = 4'd2;
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (ifc.out_data !== 4'h5) begin miscompares++; $display("FAIL bp_data cyc=%0d got=%h exp=5", i, ifc.out_data); end
            vectors++; if (ifc.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, ifc.req_ready); end
            vectors++; if (ifc.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, ifc.out_valid); end
            vectors++; if (bus_en !== 4'b0000) begin miscompares++; $display("FAIL bp_bus_en cyc=%0d got=%b exp=0000", i, bus_en); end
            ifc.req_valid = (i == 2);
            ifc.req_src   = 4'd0;
            tick();
        end
        ifc.req_valid = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        any_en_seen = 0;
        tick();
        vectors++; if (ifc.req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_no_queue_ready got=%b exp=1", ifc.req_ready); end
        vectors++; if (any_en_seen != 0) begin miscompares++; $display("FAIL bp_no_queue_en got=%0d exp=0", any_en_seen); end
    endtask

    task automatic test_illegal_src();
        ifc.out_ready = 1'b0;
        any_en_seen   = 0;
        ifc.req_src   = 4'd7;
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        vectors++; if (ifc.out_valid !== 1'b1) begin miscompares++; $display("FAIL ill_valid got=%b exp=1", ifc.out_valid); end
        vectors++; if (ifc.out_err !== 1'b1) begin miscompares++; $display("FAIL ill_err got=%b exp=1", ifc.out_err); end
        vectors++; if (ifc.out_data !== 4'h0) begin miscompares++; $display("FAIL ill_data got=%h exp=0", ifc.out_data); end
        tick();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        tick();
        vectors++; if (any_en_seen != 0) begin miscompares++; $display("FAIL ill_bus_en got=%0d exp=0", any_en_seen); end
        vectors++; if (ifc.req_ready !== 1'b1) begin miscompares++; $display("FAIL ill_release got=%b exp=1", ifc.req_ready); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_res [4];
        logic [3:0] res [4];
        int acc [4];
        int n;
        int m;
        exp_res[0] = 4'h3; exp_res[1] = 4'hA; exp_res[2] = 4'h5; exp_res[3] = 4'hF;
        for (int k = 0; k < 4; k++) begin res[k] = 4'hx; acc[k] = -100; end
        n = 0;
        m = 0;
        multi_en_seen = 0;
        ifc.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (ifc.out_valid === 1'b1 && m < 4) begin
                res[m] = ifc.out_data;
                m++;
            end
            if (ifc.req_ready === 1'b1 && n < 4) begin
                ifc.req_src   = 4'(n);
                ifc.req_valid = 1'b1;
                acc[n] = cyc;
                n++;
            end else begin
                ifc.req_valid = 1'b0;
                ifc.req_src   = 4'(cyc);
            end
            tick();
        end
        ifc.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (res[k] !== exp_res[k]) begin miscompares++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", k, res[k], exp_res[k]); end
        end
        for (int k = 1; k < 4; k++) begin
            vectors++; if (acc[k] - acc[k-1] != 4) begin miscompares++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=4", k, acc[k] - acc[k-1]); end
        end
        vectors++; if (multi_en_seen != 0) begin miscompares++; $display("FAIL b2b_onehot got=%0d exp=0", multi_en_seen); end
    endtask

    task automatic test_reset_mid_drive();
        int valid_seen;
        ifc.out_ready = 1'b1;
        ifc.req_src   = 4'd1;
        ifc.req_valid = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        vectors++; if (bus_en !== 4'b0010) begin miscompares++; $display("FAIL mid_drive_en got=%b exp=0010", bus_en); end
        rst_n = 1'b0;
        tick();
        vectors++; if (bus_en !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_bus_en got=%b exp=0000", bus_en); end
        vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got=%b exp=0", ifc.out_valid); end
        rst_n = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ifc.out_valid !== 1'b0) valid_seen++;
            tick();
        end
        vectors++; if (valid_seen != 0) begin miscompares++; $display("FAIL mid_rst_no_valid got=%0d exp=0", valid_seen); end
        vectors++; if (ifc.req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got=%b exp=1", ifc.req_ready); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        multi_en_seen = 0;
        any_en_seen   = 0;
        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_src   = 4'd0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_legal_read();
        test_backpressure();
        test_illegal_src();
        test_back_to_back();
        test_reset_mid_drive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tribus_reader.md
# tribus_reader

Read-side controller for the shared 4-bit tristate bus built from the triestado buffers (`BT`). On request, it asserts exactly one one-hot `EN` line so that a single source drives the bus. It waits a programmable settle time, captures the bus value into a register, and hands the value to the consumer with a valid/ready handshake. It sits between the tristate bus segment and any synchronous logic that needs to sample one source at a time.

## Interface
Parameters:
- `N_SRC`, default 4: number of tristate sources on the bus; range 2..16.
- `W`, default 4: bus width.
- `SETTLE`, default 1: extra enable cycles before capture; range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `req_valid`  in  1  read request.
- `req_src`  in  4  index of the source to read.
- `req_ready`  out  1  high only in IDLE.
- `bus_en`  out  N_SRC  one-hot enables, wired to `EN` of each `BT`.
- `bus_in`  in  W  shared tristate bus value.
- `out_data`  out  W  captured value.
- `out_err`  out  1  qualifies `out_data`; set when `req_src >= N_SRC`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.

## Operation
States: IDLE, DRIVE, HOLD.
- **IDLE**
  - `req_ready=1`, `bus_en=0`.
  - On `req_valid & req_ready` with a legal source: latch `req_src`, load the settle counter with `SETTLE`, go to DRIVE.
  - Illegal source (`req_src >= N_SRC`): go directly to HOLD with `out_err=1` and `out_data=0`. No enable is ever asserted.
- **DRIVE**
  - `bus_en = 1 << src`; `req_ready=0`.
  - While the counter is nonzero, decrement it.
  - When the counter is 0: capture `bus_in` into `out_data`, clear `out_err`, go to HOLD.
- **HOLD**
  - `out_valid=1`, `bus_en=0`.
  - `out_data` and `out_err` stay stable until the handshake.
  - On `out_ready`, go to IDLE.
- `bus_en` has at most one bit set in every cycle. It is all-zero in IDLE and HOLD, where the bus floats; that is legal.
- A new request is ignored until IDLE. No request is queued, and there is no IDLE bypass from HOLD.
- `bus_in` is sampled only at the capture edge. Z or X on `bus_in` at other times has no effect.

## Timing
- **Reset values:** state IDLE, `bus_en=0`, `out_valid=0`, `out_err=0`, `out_data=0`, `req_ready=1`, counter 0.
- **Reset mid-operation:** `rst_n` low at any edge, including during DRIVE or HOLD, forces all reset values at that edge. The pending result is discarded.
- **Legal read:**
  - Accept at edge E0.
  - `bus_en` is high for exactly `SETTLE+1` cycles.
  - Capture happens at edge E(`SETTLE+1`), and `out_valid` rises at that same edge.
  - Accept-to-valid latency is `SETTLE+1` cycles.
- **Illegal read:** `out_valid` rises at E1, latency 1 cycle.
- **Handshake:**
  - `out_valid & out_ready` at edge Ek moves to IDLE at Ek.
  - `req_ready` is high from Ek, so the next accept is no earlier than Ek+1.
  - Minimum spacing between legal reads is therefore `SETTLE+3` cycles.
- `out_ready` held high permanently is legal. HOLD then lasts exactly 1 cycle.
- `req_src` changing during DRIVE has no effect, because the source is latched at accept.

## Structure
- **Shared package `tribus_pkg`:** state enum (IDLE, DRIVE, HOLD), constants `TRIBUS_W=4`, `TRIBUS_NSRC=4`, `TRIBUS_SETTLE_DEF=1`.
- **Sub-module `onehot_dec`:** index-to-one-hot decoder with an enable and an out-of-range flag. It produces `bus_en` and the illegal-source detection.
- **Top level:** FSM, settle counter, result register.
- **Bench:** instantiates four `BT` drivers sharing one `wire [3:0]` bus. The bench drives each `BT` `S` input with a distinct constant.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles, then release. Required: `bus_en=0000`, `out_valid=0`, `out_data=0000`, `req_ready=1`.
- **Legal read, `SETTLE=1`:** sources hold 4'h3, 4'hA, 4'h5, 4'hF. Request `req_src=2`. Required:
  - `bus_en=0100` for 2 cycles.
  - `out_valid` 2 cycles after accept, with `out_data=0101`, `out_err=0`.
  - `bus_en=0000` while `out_valid=1`.
- **Backpressure:** as the legal read, but hold `out_ready=0` for 5 cycles. Required:
  - `out_data` stable at 0101 and `req_ready=0` throughout.
  - A `req_valid` pulse with `req_src=0` in that window is ignored.
- **Illegal source:** request `req_src=7`. Required: `bus_en` never nonzero; `out_valid` 1 cycle after accept with `out_err=1`, `out_data=0000`.
- **Back-to-back:** `out_ready=1` permanently, requests for sources 0, 1, 2, 3. Required:
  - Results 4'h3, 4'hA, 4'h5, 4'hF in order.
  - Accepts 4 cycles apart.
  - At most one `bus_en` bit ever set.
- **Reset mid-DRIVE:** assert `rst_n=0` in the first DRIVE cycle. Required: `bus_en=0000` at that edge, no `out_valid`, `req_ready=1` after release.
